snake_dir_ctrl: RTL

//   Direction controller and move-tick generator directly upstream of the head-next stage.

---
 rtl/snake_pkg.sv | 18 +
 rtl/snake_tick_gen.sv | 35 +++
 rtl/snake_dir_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared snake definitions: direction encoding and the opposite-direction helper.
// Used by the direction controller, head-next and collision stages.
package snake_pkg;

  // 00 = +x, 01 = +y, 10 = -x, 11 = -y
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_UP    = 2'b11
  } dir_e;

  // Flipping the MSB turns a direction around on the same axis.
  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-tick generator: counts enabled cycles and flags the last one of each period.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   clr    in  synchronous restart
//   en     in  count enable
//   step   out high on the enabled cycle where the counter sits at TICK_DIV-1
module snake_tick_gen #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned CNT_W    = $clog2(TICK_DIV) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign step = en & (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Direction controller: edge-detects the direction buttons, keeps one pending turn,
// rejects reversals and commits the direction on every move step.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clr       in   synchronous restart, same effect as reset
//   en        in   game running; gates the move tick
//   btn[3:0]  in   button levels [0]=right [1]=down [2]=left [3]=up
//   cur_dir   out  committed direction
//   next_dir  out  direction for the coming step
//   step      out  one-cycle move pulse
//   pend      out  a turn request is pending
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned CNT_W    = $clog2(TICK_DIV) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] btn,
  output logic [1:0] cur_dir,
  output logic [1:0] next_dir,
  output logic       step,
  output logic       pend
);

  dir_e       cur_dir_q;
  dir_e       pend_dir_q;
  logic       pend_q;
  logic [3:0] btn_q;

  logic [3:0] press;
  logic       press_vld;
  dir_e       press_dir;
  dir_e       next_dir_w;
  dir_e       ref_dir;
  logic       accept;
  logic       step_w;

  snake_tick_gen #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (en),
    .step (step_w)
  );

  assign press     = btn & ~btn_q;
  assign press_vld = |press;

  // Lowest button index wins when several are pressed together.
  always_comb begin
    press_dir = DIR_RIGHT;
    if (press[0])      press_dir = DIR_RIGHT;
    else if (press[1]) press_dir = DIR_DOWN;
    else if (press[2]) press_dir = DIR_LEFT;
    else if (press[3]) press_dir = DIR_UP;
  end

  assign next_dir_w = pend_q ? pend_dir_q : cur_dir_q;

  // In a step cycle the press is judged against the direction being committed,
  // so a turn can never reverse the snake across a step boundary.
  assign ref_dir = step_w ? next_dir_w : cur_dir_q;
  assign accept  = press_vld && (press_dir != ref_dir) && (press_dir != opposite(ref_dir));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_dir_q  <= DIR_RIGHT;
      pend_dir_q <= DIR_RIGHT;
      pend_q     <= 1'b0;
      btn_q      <= '0;
    end else if (clr) begin
      cur_dir_q  <= DIR_RIGHT;
      pend_dir_q <= DIR_RIGHT;
      pend_q     <= 1'b0;
      btn_q      <= '0;
    end else begin
      btn_q <= btn;
      if (step_w) begin
        cur_dir_q <= next_dir_w;
        pend_q    <= 1'b0;
      end
      // Latest accepted press wins, including one arriving in a step cycle.
      if (accept) begin
        pend_q     <= 1'b1;
        pend_dir_q <= press_dir;
      end
    end
  end

  assign cur_dir  = cur_dir_q;
  assign next_dir = next_dir_w;
  assign step     = step_w;
  assign pend     = pend_q;

endmodule
